// File: rtl/branch_sequencer_if.sv
// branch_sequencer_if: request, operand and control-strobe bundle between the control unit and branch_sequencer.
// Latency: none (wires only).
// Backpressure: none; start is a plain request that the sequencer accepts only while idle.
interface branch_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int STAT_WIDTH = 16
);
  logic                  start;
  logic [31:0]           ir;
  logic [DATA_WIDTH-1:0] bus_in;
  logic                  gra;
  logic                  rout;
  logic                  con_in;
  logic                  pc_out;
  logic                  y_in;
  logic                  c_out;
  logic                  add;
  logic                  zlow_in;
  logic                  zlow_out;
  logic                  pc_in;
  logic                  con_ff;
  logic                  busy;
  logic                  done;
  logic [STAT_WIDTH-1:0] taken_count;
  logic [STAT_WIDTH-1:0] not_taken_count;

  // control unit side: issues the request, observes strobes and status
  modport master (
    output start, ir, bus_in,
    input  gra, rout, con_in, pc_out, y_in, c_out, add, zlow_in, zlow_out,
    input  pc_in, con_ff, busy, done, taken_count, not_taken_count
  );

  // sequencer side
  modport slave (
    input  start, ir, bus_in,
    output gra, rout, con_in, pc_out, y_in, c_out, add, zlow_in, zlow_out,
    output pc_in, con_ff, busy, done, taken_count, not_taken_count
  );
endinterface

// File: rtl/branch_sequencer.sv
// branch_sequencer: runs T3..T6 of br* instructions (Ra test into CON, PC+C via Y/ALU/Z, PC load when taken).
// Latency: done 5 cycles after the start edge (taken or EARLY_EXIT=0), 2 cycles for an early not-taken exit.
// Backpressure: none; start is sampled only in IDLE and dropped while busy. Macro BR_STATS_EN adds branch counters.
module branch_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int C2_LSB     = 19,
  parameter int EARLY_EXIT = 1,
  parameter int STAT_WIDTH = 16
) (
  input logic               clock,
  input logic               clear,
  branch_sequencer_if.slave br
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T3   = 3'd1,
    S_T4   = 3'd2,
    S_T5   = 3'd3,
    S_T6   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] c2_q;
  logic       con_q;
  logic       cond;
  logic       unused_ir;

  // only the C2 field of ir matters here; fold the rest so it is visibly consumed
  assign unused_ir = ^(br.ir & ~(32'h3 << C2_LSB));

  // branch condition on the value currently on the bus (meaningful in T3)
  always_comb begin
    cond = 1'b0;
    case (c2_q)
      2'b00:   cond = (br.bus_in == '0);
      2'b01:   cond = (br.bus_in != '0);
      2'b10:   cond = ~br.bus_in[DATA_WIDTH-1];
      default: cond = br.bus_in[DATA_WIDTH-1];
    endcase
  end

  // state register; clear aborts any branch in flight
  always_ff @(posedge clock) begin
    if (!clear) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state: a not-taken branch may leave straight from T3 when early exit is enabled
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (br.start) state_nxt = S_T3;
      S_T3:    state_nxt = ((EARLY_EXIT != 0) && !cond) ? S_DONE : S_T4;
      S_T4:    state_nxt = S_T5;
      S_T5:    state_nxt = S_T6;
      S_T6:    state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // capture the condition field when a request is accepted
  always_ff @(posedge clock) begin
    if (!clear)                            c2_q <= 2'b00;
    else if (state == S_IDLE && br.start)  c2_q <= br.ir[C2_LSB +: 2];
  end

  // CON flip-flop loads at the end of T3 and holds until the next T3
  always_ff @(posedge clock) begin
    if (!clear)              con_q <= 1'b0;
    else if (state == S_T3)  con_q <= cond;
  end

  // Moore strobe decode; each bus driver belongs to exactly one state
  always_comb begin
    br.gra      = 1'b0;
    br.rout     = 1'b0;
    br.con_in   = 1'b0;
    br.pc_out   = 1'b0;
    br.y_in     = 1'b0;
    br.c_out    = 1'b0;
    br.add      = 1'b0;
    br.zlow_in  = 1'b0;
    br.zlow_out = 1'b0;
    br.pc_in    = 1'b0;
    br.done     = 1'b0;
    br.busy     = (state != S_IDLE);
    case (state)
      S_T3: begin
        br.gra    = 1'b1;
        br.rout   = 1'b1;
        br.con_in = 1'b1;
      end
      S_T4: begin
        br.pc_out = 1'b1;
        br.y_in   = 1'b1;
      end
      S_T5: begin
        br.c_out   = 1'b1;
        br.add     = 1'b1;
        br.zlow_in = 1'b1;
      end
      S_T6: begin
        br.zlow_out = 1'b1;
        br.pc_in    = con_q;
      end
      S_DONE:  br.done = 1'b1;
      default: ;
    endcase
  end

  assign br.con_ff = con_q;

`ifdef BR_STATS_EN
  logic [STAT_WIDTH-1:0] taken_q;
  logic [STAT_WIDTH-1:0] not_taken_q;
  logic                  done_entry;
  logic                  branch_taken;

  // an early exit enters DONE on the same edge CON loads, so use the live condition there
  assign done_entry   = (state_nxt == S_DONE) && (state != S_DONE);
  assign branch_taken = (state == S_T3) ? cond : con_q;

  // saturating taken / not-taken counters, bumped once per completed branch
  always_ff @(posedge clock) begin
    if (!clear) begin
      taken_q     <= '0;
      not_taken_q <= '0;
    end else if (done_entry) begin
      if (branch_taken) begin
        if (taken_q != '1) taken_q <= taken_q + 1'b1;
      end else begin
        if (not_taken_q != '1) not_taken_q <= not_taken_q + 1'b1;
      end
    end
  end

  assign br.taken_count     = taken_q;
  assign br.not_taken_count = not_taken_q;
`else
  assign br.taken_count     = {STAT_WIDTH{1'b0}};
  assign br.not_taken_count = {STAT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: two sequencers (early exit on / off, 16- and 2-bit counters) driven in lockstep.
// Latency: each branch is observed for six cycles after its start edge, strobe by strobe.
// Backpressure: start is pulsed only when both instances are idle, except in the deliberate ignore tests.
module tb_branch_sequencer;

  logic        clk;
  logic        clear;
  logic        start;
  logic [31:0] ir;
  logic [31:0] bus_in;

  int checks   = 0;
  int failures = 0;

`ifdef BR_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  branch_sequencer_if #(.DATA_WIDTH(32), .STAT_WIDTH(16)) ifa ();
  branch_sequencer_if #(.DATA_WIDTH(32), .STAT_WIDTH(2))  ifb ();

  assign ifa.start  = start;
  assign ifa.ir     = ir;
  assign ifa.bus_in = bus_in;
  assign ifb.start  = start;
  assign ifb.ir     = ir;
  assign ifb.bus_in = bus_in;

  branch_sequencer #(.DATA_WIDTH(32), .C2_LSB(19), .EARLY_EXIT(1), .STAT_WIDTH(16)) dut_a (
    .clock (clk),
    .clear (clear),
    .br    (ifa)
  );

  branch_sequencer #(.DATA_WIDTH(32), .C2_LSB(19), .EARLY_EXIT(0), .STAT_WIDTH(2)) dut_b (
    .clock (clk),
    .clear (clear),
    .br    (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] vec_a;
  logic [11:0] vec_b;
  assign vec_a = {ifa.busy, ifa.gra, ifa.rout, ifa.con_in, ifa.pc_out, ifa.y_in,
                  ifa.c_out, ifa.add, ifa.zlow_in, ifa.zlow_out, ifa.pc_in, ifa.done};
  assign vec_b = {ifb.busy, ifb.gra, ifb.rout, ifb.con_in, ifb.pc_out, ifb.y_in,
                  ifb.c_out, ifb.add, ifb.zlow_in, ifb.zlow_out, ifb.pc_in, ifb.done};

  // reference state: last CON value and branch counts per instance
  bit con_a, con_b;
  int tk_a, nt_a, tk_b, nt_b;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] bus;
    bit          taken;
    string       name;
  } vec_t;

  vec_t tbl[10];

  // branch rule from the instruction set: zero, non-zero, plus, minus
  function automatic bit model_taken(input logic [1:0] c2, input logic [31:0] v);
    case (c2)
      2'd0:    return v == 32'd0;
      2'd1:    return v != 32'd0;
      2'd2:    return $signed(v) >= 0;
      default: return $signed(v) < 0;
    endcase
  endfunction

  // step number (0 = idle, 3..6 = T3..T6, 7 = done) seen c cycles after the start edge
  function automatic int model_phase(input int c, input bit ee, input bit taken);
    int len;
    len = (ee && !taken) ? 2 : 5;
    if (c > len)  return 0;
    if (c == len) return 7;
    return c + 2;
  endfunction

  // control word expected in a given step: {busy,gra,rout,con_in,pc_out,y_in,c_out,add,zlow_in,zlow_out,pc_in,done}
  function automatic logic [11:0] exp_vec(input int ph, input bit taken);
    case (ph)
      3:       return 12'b1111_0000_0000;
      4:       return 12'b1000_1100_0000;
      5:       return 12'b1000_0011_1000;
      6:       return 12'b1000_0000_0100 | {10'd0, taken, 1'b0};
      7:       return 12'b1000_0000_0001;
      default: return 12'b0000_0000_0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, " a taken_count"},     {16'd0, ifa.taken_count},     STATS_ON ? tk_a : 0);
    chk({tag, " a not_taken_count"}, {16'd0, ifa.not_taken_count}, STATS_ON ? nt_a : 0);
    chk({tag, " b taken_count"},     {30'd0, ifb.taken_count},     STATS_ON ? tk_b : 0);
    chk({tag, " b not_taken_count"}, {30'd0, ifb.not_taken_count}, STATS_ON ? nt_b : 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    con_a = 0; con_b = 0;
    tk_a = 0; nt_a = 0; tk_b = 0; nt_b = 0;
  endtask

  task automatic do_reset();
    clear = 1'b0;
    start = 1'b0;
    cycle();
    clear = 1'b1;
    model_reset();
  endtask

  // one branch request from idle, checked cycle by cycle on both instances
  task automatic run_branch(input logic [31:0] ir_v, input logic [31:0] bus_v, input bit taken, input string tag);
    start = 1'b1;
    ir = ir_v;
    bus_in = bus_v;
    for (int c = 1; c <= 6; c++) begin
      cycle();
      if (c == 1) begin
        start = 1'b0;
        ir = $urandom;
      end
      if (c == 2) bus_in = $urandom;
      chk($sformatf("%s a strobes c%0d", tag, c), {20'd0, vec_a}, {20'd0, exp_vec(model_phase(c, 1'b1, taken), taken)});
      chk($sformatf("%s b strobes c%0d", tag, c), {20'd0, vec_b}, {20'd0, exp_vec(model_phase(c, 1'b0, taken), taken)});
      chk($sformatf("%s a con_ff c%0d", tag, c), {31'd0, ifa.con_ff}, (c == 1) ? con_a : taken);
      chk($sformatf("%s b con_ff c%0d", tag, c), {31'd0, ifb.con_ff}, (c == 1) ? con_b : taken);
    end
    con_a = taken;
    con_b = taken;
    if (taken) begin
      tk_a = (tk_a == 65535) ? tk_a : tk_a + 1;
      tk_b = (tk_b == 3) ? tk_b : tk_b + 1;
    end else begin
      nt_a = (nt_a == 65535) ? nt_a : nt_a + 1;
      nt_b = (nt_b == 3) ? nt_b : nt_b + 1;
    end
    chk_counts(tag);
  endtask

  initial begin
    int pa[7];
    int pb[7];
    logic [31:0] ir_v;
    logic [31:0] bus_v;
    logic [1:0]  c2;
    int          gap;

    tbl[0] = '{32'h91200023, 32'h00000000, 1'b1, "brzr zero"};
    tbl[1] = '{32'h91200023, 32'h00000005, 1'b0, "brzr five"};
    tbl[2] = '{32'h91280023, 32'h00000000, 1'b0, "brnz zero"};
    tbl[3] = '{32'h91280023, 32'h80000000, 1'b1, "brnz msb"};
    tbl[4] = '{32'h91300023, 32'h80000000, 1'b0, "brpl msb"};
    tbl[5] = '{32'h91380023, 32'h80000000, 1'b1, "brmi msb"};
    tbl[6] = '{32'h91300023, 32'h7fffffff, 1'b1, "brpl max"};
    tbl[7] = '{32'h91380023, 32'h00000001, 1'b0, "brmi one"};
    tbl[8] = '{32'h91300023, 32'h00000000, 1'b1, "brpl zero"};
    tbl[9] = '{32'h91200023, 32'hffffffff, 1'b0, "brzr ones"};

    clear = 1'b0;
    start = 1'b0;
    ir = 32'd0;
    bus_in = 32'd0;
    model_reset();
    cycle();
    cycle();
    chk("reset a strobes", {20'd0, vec_a}, 32'd0);
    chk("reset b strobes", {20'd0, vec_b}, 32'd0);
    chk("reset a con_ff", {31'd0, ifa.con_ff}, 32'd0);
    chk("reset b con_ff", {31'd0, ifb.con_ff}, 32'd0);
    chk_counts("reset");
    clear = 1'b1;
    cycle();

    for (int i = 0; i < 10; i++) begin
      run_branch(tbl[i].ir, tbl[i].bus, tbl[i].taken, tbl[i].name);
    end

    // start held high throughout: ignored while busy and in DONE, re-accepted from IDLE
    pa = '{3, 7, 0, 3, 7, 0, 3};
    pb = '{3, 4, 5, 6, 7, 0, 3};
    start = 1'b1;
    ir = 32'h91200023;
    bus_in = 32'h00000005;
    for (int c = 0; c < 7; c++) begin
      cycle();
      chk($sformatf("held start a c%0d", c + 1), {20'd0, vec_a}, {20'd0, exp_vec(pa[c], 1'b0)});
      chk($sformatf("held start b c%0d", c + 1), {20'd0, vec_b}, {20'd0, exp_vec(pb[c], 1'b0)});
    end
    do_reset();

    // clear during T5 aborts a taken branch; a start during T4 is ignored
    start = 1'b1;
    ir = 32'h91200023;
    bus_in = 32'h00000000;
    cycle();
    start = 1'b0;
    chk("abort a T3", {20'd0, vec_a}, {20'd0, exp_vec(3, 1'b1)});
    cycle();
    chk("abort a T4", {20'd0, vec_a}, {20'd0, exp_vec(4, 1'b1)});
    chk("abort a con_ff set", {31'd0, ifa.con_ff}, 32'd1);
    start = 1'b1;
    cycle();
    chk("abort a T5 after start in T4", {20'd0, vec_a}, {20'd0, exp_vec(5, 1'b1)});
    chk("abort b T5 after start in T4", {20'd0, vec_b}, {20'd0, exp_vec(5, 1'b1)});
    start = 1'b0;
    clear = 1'b0;
    cycle();
    model_reset();
    chk("abort a idle", {20'd0, vec_a}, 32'd0);
    chk("abort b idle", {20'd0, vec_b}, 32'd0);
    chk("abort a con_ff", {31'd0, ifa.con_ff}, 32'd0);
    chk("abort b con_ff", {31'd0, ifb.con_ff}, 32'd0);
    chk_counts("abort");
    clear = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk($sformatf("post abort a c%0d", c), {20'd0, vec_a}, 32'd0);
      chk($sformatf("post abort b c%0d", c), {20'd0, vec_b}, 32'd0);
    end

    // counters: 3 taken + 2 not taken, then 5 more taken to saturate the 2-bit instance
    do_reset();
    for (int i = 0; i < 3; i++) run_branch(32'h91200023, 32'h00000000, 1'b1, $sformatf("stat tk%0d", i));
    for (int i = 0; i < 2; i++) run_branch(32'h91200023, 32'h00000005, 1'b0, $sformatf("stat nt%0d", i));
    for (int i = 0; i < 5; i++) run_branch(32'h91380023, 32'h80000000, 1'b1, $sformatf("stat sat%0d", i));

    // random branches against the reference rules
    for (int i = 0; i < 40; i++) begin
      c2 = 2'($urandom_range(0, 3));
      ir_v = $urandom;
      ir_v[20:19] = c2;
      case ($urandom_range(0, 3))
        0:       bus_v = 32'd0;
        1:       bus_v = $urandom;
        2:       bus_v = $urandom | 32'h80000000;
        default: bus_v = $urandom & 32'h7fffffff;
      endcase
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        cycle();
        chk($sformatf("rnd%0d a idle gap", i), {20'd0, vec_a}, 32'd0);
      end
      run_branch(ir_v, bus_v, model_taken(c2, bus_v), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
